// File: rtl/mux_rr_arb_n_ch_if.sv
// Handshake bundle for the CH-channel arbitrated mux: CH valid/ready
// producer channels in, one registered valid/ready channel out.
interface mux_rr_arb_n_ch_if #(
  parameter int N     = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2
);
  logic [CH*N-1:0]  in_data;
  logic [CH-1:0]    in_valid;
  logic [CH-1:0]    in_ready;
  logic             sel_en;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_sel;

  modport master (
    output in_data, in_valid, sel_en, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, sel_en, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_rr_arb_n_ch.sv
// CH-input valid/ready mux, round-robin or fixed-priority arbitration,
// select override, single registered output. Ports: clk, rst_n, bus (slave).
module mux_rr_arb_n_ch #(
  parameter int N     = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2,
  parameter int MODE  = 0
) (
  input  logic clk,
  input  logic rst_n,
  mux_rr_arb_n_ch_if.slave bus
);
  localparam logic [SEL_W:0]   CH_W = (SEL_W+1)'(CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CH-1);

  logic [N-1:0]     ch_data [CH];
  logic [CH-1:0]    mask;
  logic [CH-1:0]    elig;
  logic [CH-1:0]    rdy;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W:0]   sum;
  logic             gnt_vld;
  logic             load_en;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    assign ch_data[k] = bus.in_data[k*N +: N];
    // an out-of-range sel matches no channel, leaving the set empty
    assign mask[k] = !bus.sel_en || (bus.sel == SEL_W'(k));
    assign rdy[k]  = load_en & gnt_vld & (gnt == SEL_W'(k));
  end

  assign elig    = bus.in_valid & mask;
  assign load_en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = rst_n ? rdy : '0;

  // search starts at ptr (round-robin) or 0 (priority), wrapping mod CH
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    sum     = '0;
    for (int i = 0; i < CH; i++) begin
      sum = (MODE == 0) ? ({1'b0, ptr} + (SEL_W+1)'(i))
                        : (SEL_W+1)'(i);
      if (sum >= CH_W)
        sum = sum - CH_W;
      if (!gnt_vld && elig[sum[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = sum[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
    end else if (load_en) begin
      bus.out_valid <= gnt_vld;
      if (gnt_vld) begin
        bus.out_data <= ch_data[gnt];
        bus.out_sel  <= gnt;
        if (MODE == 0 && !bus.sel_en)
          ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule
